uart_receiver: RTL and testbench

//  Receive end of the 8N1 UART link driven by UART_sender. Samples the serial

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_receiver.sv | 127 ++++++++++++
 tb/tb_uart_receiver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial RX pin plus received-byte outputs of the 8N1 receiver.
// master drives the line and consumes results; slave is the receiver itself.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       done;
  logic       busy;
  logic       frame_error;

  modport master (
    output rx,
    input  data_out,
    input  done,
    input  busy,
    input  frame_error
  );

  modport slave (
    input  rx,
    output data_out,
    output done,
    output busy,
    output frame_error
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-FF synchronised rx, mid-bit sampling, one-cycle done/frame_error strobes.
// done lands at mid stop bit (~2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after the start edge); no backpressure.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEAN_UP  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          done_q, done_nxt;
  logic          ferr_q, ferr_nxt;
  logic          busy_q;

  assign bus.data_out    = data_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.frame_error = ferr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta   <= bus.rx;
      rx_s      <= rx_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_nxt;
      data_q    <= data_nxt;
      done_q    <= done_nxt;
      ferr_q    <= ferr_nxt;
      busy_q    <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    data_nxt    = data_q;
    done_nxt    = 1'b0;
    ferr_nxt    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        if (!rx_s) state_nxt = START_BIT;
      end

      START_BIT: begin
        if (cnt == CNT_MID) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_nxt   = rx_s ? IDLE : DATA_BITS;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DATA_BITS: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_nxt = STOP_BIT;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      STOP_BIT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = CLEAN_UP;
          if (rx_s) begin
            data_nxt = shift_reg;
            done_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      CLEAN_UP: begin
        cnt_nxt = '0;
        // A held-low line (break) must return high before a new start edge counts.
        if (rx_s) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised bench for uart_receiver: drives 8N1 frames and checks against a queue-based model of expected events.
module tb_uart_receiver;

  localparam int CPB = 8;
  localparam int MID = (CPB - 1) / 2;

  typedef struct {
    bit         fe;
    logic [7:0] b;
  } ev_t;

  logic clk;
  logic rst_n;
  uart_rx_if bus ();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned good_cnt = 0;
  int unsigned fe_cnt   = 0;
  ev_t         exp_q[$];
  int unsigned done_times[$];
  logic [7:0]  model_good;
  logic        done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference scoreboard: every strobe must match the next queued event.
  always @(negedge clk) begin
    ev_t ev;
    if (bus.done || bus.frame_error)
      check("done_fe_excl", 32'(bus.done & bus.frame_error), 32'd0);
    if (bus.done) begin
      good_cnt <= good_cnt + 1;
      done_times.push_back(cyc);
      check("busy_at_done", 32'(bus.busy), 32'd1);
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        ev = exp_q.pop_front();
        check("done_kind", 32'(ev.fe), 32'd0);
        check("data_out", 32'(bus.data_out), 32'(ev.b));
      end
    end
    if (bus.frame_error) begin
      fe_cnt <= fe_cnt + 1;
      if (exp_q.size() == 0) check("unexpected_ferr", 32'd1, 32'd0);
      else begin
        ev = exp_q.pop_front();
        check("ferr_kind", 32'(ev.fe), 32'd1);
        check("ferr_data_hold", 32'(bus.data_out), 32'(ev.b));
      end
    end
    if (done_prev) check("busy_drop", 32'(bus.busy), 32'd0);
    done_prev <= bus.done;
  end

  task automatic send_bit(input logic v);
    bus.rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    ev_t ev;
    ev.fe = 1'b0;
    ev.b  = b;
    exp_q.push_back(ev);
    model_good = b;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int unsigned t_fall, lat, busy_run, fe_before, good_before;
    logic [7:0] b;
    ev_t ev;

    // Reset with the line held low
    rst_n = 1'b0;
    bus.rx = 1'b0;
    model_good = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_data", 32'(bus.data_out), 32'h00);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ferr", 32'(bus.frame_error), 32'd0);
    bus.rx = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_rst", 32'(bus.busy), 32'd0);

    // Single frame 0x7F with latency window
    done_times.delete();
    t_fall = cyc;
    expect_byte(8'h7F);
    send_frame(8'h7F, 1'b1);
    send_bit(1'b1);
    wait_drain("drain_7f");
    check("data_7f", 32'(bus.data_out), 32'h7F);
    check("fe_none_7f", 32'(fe_cnt), 32'd0);
    if (done_times.size() > 0) begin
      lat = done_times[0] - t_fall;
      check("latency_window", 32'(lat >= 76 && lat <= 80), 32'd1);
    end

    // Back-to-back frames, no idle gap
    done_times.delete();
    expect_byte(8'hA5);
    expect_byte(8'h3C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_bit(1'b1);
    wait_drain("drain_b2b");
    check("b2b_count", 32'(done_times.size()), 32'd2);
    if (done_times.size() == 2)
      check("b2b_spacing", done_times[1] - done_times[0], 32'(10 * CPB));
    check("data_3c", 32'(bus.data_out), 32'h3C);

    // Two-cycle glitch: busy only for START_BIT duration
    bus.rx = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx = 1'b1;
    busy_run = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (bus.busy) busy_run++;
    end
    check("glitch_busy_len", busy_run, 32'(MID + 1));
    check("glitch_data", 32'(bus.data_out), 32'(model_good));
    check("glitch_no_event", 32'(exp_q.size()), 32'd0);

    // Frame error: 0x55 with low stop bit, line held low 3 bit-times
    fe_before = fe_cnt;
    ev.fe = 1'b1;
    ev.b  = model_good;
    exp_q.push_back(ev);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b_of(8'h55, i));
    repeat (3) send_bit(1'b0);
    check("break_busy", 32'(bus.busy), 32'd1);
    bus.rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("break_released", 32'(bus.busy), 32'd0);
    check("ferr_pulses", fe_cnt - fe_before, 32'd1);
    check("ferr_data_keep", 32'(bus.data_out), 32'(model_good));
    wait_drain("drain_fe");

    // Reset after bit 3 of 0xFF aborts the frame
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_data", 32'(bus.data_out), 32'h00);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_ferr", 32'(bus.frame_error), 32'd0);
    model_good = 8'h00;
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);
    check("midrst_quiet", 32'(bus.busy), 32'd0);
    expect_byte(8'h12);
    send_frame(8'h12, 1'b1);
    send_bit(1'b1);
    wait_drain("drain_12");
    check("data_12", 32'(bus.data_out), 32'h12);

    // Random traffic: gaps, glitches, back-to-back
    good_before = good_cnt;
    for (int n = 0; n < 256; n++) begin
      repeat ($urandom_range(0, 24)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        bus.rx = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        bus.rx = 1'b1;
        repeat (CPB) @(negedge clk);
      end
      b = 8'($urandom_range(0, 255));
      expect_byte(b);
      send_frame(b, 1'b1);
    end
    send_bit(1'b1);
    wait_drain("drain_rand");
    check("rand_count", good_cnt - good_before, 32'd256);
    check("rand_last", 32'(bus.data_out), 32'(model_good));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic b_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
